// File: rtl/conv2_stream_if.sv
// conv2_stream_if: kernel-load, pixel-in and result-out stream signals of conv2_stream
interface conv2_stream_if #(parameter int WIDTH_BIT = 8);
  logic kload_valid;
  logic signed [WIDTH_BIT-1:0] kload_data;
  logic start;
  logic pix_valid;
  logic pix_ready;
  logic signed [WIDTH_BIT-1:0] pix_data;
  logic out_valid;
  logic out_ready;
  logic signed [WIDTH_BIT-1:0] out_data;
  logic busy;
  logic done;
  modport master (output kload_valid, kload_data, start, pix_valid, pix_data, out_ready,
                  input pix_ready, out_valid, out_data, busy, done);
  modport slave (input kload_valid, kload_data, start, pix_valid, pix_data, out_ready,
                 output pix_ready, out_valid, out_data, busy, done);
endinterface

// File: rtl/conv2_stream.sv
// conv2_stream: streaming KSIZE x KSIZE correlation over line buffers with stride, shift and saturation.
// Defining CONV2_STREAM_RELU_EN clamps negative results to zero in the output register.
module conv2_stream #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int KSIZE = 3,
  parameter int WIDTH_BIT = 8,
  parameter int STRIDE = 1,
  parameter int SHIFT = 0
) (
  input logic clock,
  input logic reset,
  conv2_stream_if.slave s
);
  localparam int NK = KSIZE * KSIZE;
  localparam int ACC_W = 2 * WIDTH_BIT + $clog2(NK) + 1;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int IW = $clog2(NK);
  localparam int PW = STRIDE > 1 ? $clog2(STRIDE) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_K = CW'(KSIZE - 1);
  localparam logic [RW-1:0] R_K = RW'(KSIZE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NK - 1);
  localparam logic [PW-1:0] P_LAST = PW'(STRIDE - 1);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2 ** (WIDTH_BIT - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;
  logic signed [WIDTH_BIT-1:0] r_ker [NK];
  logic signed [WIDTH_BIT-1:0] r_lb [KSIZE-1][IMG_W];
  logic signed [WIDTH_BIT-1:0] r_win [KSIZE][KSIZE-1];
  logic signed [WIDTH_BIT-1:0] w_cur [KSIZE][KSIZE];
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [PW-1:0] r_cph, r_rph;
  logic r_out_valid;
  logic signed [WIDTH_BIT-1:0] r_out_data;
  logic w_acc, w_fire;
  logic signed [ACC_W-1:0] w_sum, w_sh;
  logic signed [WIDTH_BIT-1:0] w_sat, w_res;
  assign s.out_valid = r_out_valid;
  assign s.out_data = r_out_data;
  always_comb begin
    w_next = r_state;
    s.pix_ready = r_state == S_RUN && (!r_out_valid || s.out_ready);
    s.busy = r_state == S_RUN || r_state == S_DRAIN;
    s.done = r_state == S_DONE;
    w_acc = s.pix_valid && s.pix_ready;
    case (r_state)
      S_IDLE: w_next = s.start ? S_RUN : S_IDLE;
      S_RUN: w_next = (w_acc && r_row == R_LAST && r_col == C_LAST) ? S_DRAIN : S_RUN;
      S_DRAIN: w_next = (!r_out_valid || s.out_ready) ? S_DONE : S_DRAIN;
      default: w_next = S_IDLE;
    endcase
  end
  // Window = K-1 registered history columns plus the column formed by the line buffers and the incoming pixel.
  always_comb begin
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE - 1; j++) w_cur[i][j] = r_win[i][j];
    for (int i = 0; i < KSIZE - 1; i++) w_cur[i][KSIZE-1] = r_lb[KSIZE-2-i][r_col];
    w_cur[KSIZE-1][KSIZE-1] = s.pix_data;
    w_sum = '0;
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE; j++)
        w_sum = w_sum + ACC_W'(w_cur[i][j]) * ACC_W'(r_ker[i*KSIZE+j]);
    w_sh = w_sum >>> SHIFT;
    w_sat = w_sh > MAXV ? MAXV[WIDTH_BIT-1:0] : w_sh < MINV ? MINV[WIDTH_BIT-1:0] : w_sh[WIDTH_BIT-1:0];
  end
`ifdef CONV2_STREAM_RELU_EN
  assign w_res = w_sat[WIDTH_BIT-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif
  assign w_fire = w_acc && r_row >= R_K && r_col >= C_K && r_rph == '0 && r_cph == '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_col <= '0;
      r_row <= '0;
      r_cph <= '0;
      r_rph <= '0;
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      for (int k = 0; k < NK; k++) r_ker[k] <= '0;
      for (int k = 0; k < KSIZE - 1; k++)
        for (int c = 0; c < IMG_W; c++) r_lb[k][c] <= '0;
      for (int i = 0; i < KSIZE; i++)
        for (int j = 0; j < KSIZE - 1; j++) r_win[i][j] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && s.kload_valid) begin
        r_ker[r_idx] <= s.kload_data;
        r_idx <= r_idx == I_LAST ? '0 : r_idx + 1'b1;
      end
      if (r_state == S_IDLE && s.start) begin
        r_idx <= '0;
        r_col <= '0;
        r_row <= '0;
        r_cph <= '0;
        r_rph <= '0;
      end
      if (w_acc) begin
        r_col <= r_col == C_LAST ? '0 : r_col + 1'b1;
        r_cph <= r_col == C_LAST ? '0 : r_col >= C_K ? (r_cph == P_LAST ? '0 : r_cph + 1'b1) : r_cph;
        if (r_col == C_LAST) begin
          r_row <= r_row == R_LAST ? '0 : r_row + 1'b1;
          r_rph <= r_row >= R_K ? (r_rph == P_LAST ? '0 : r_rph + 1'b1) : r_rph;
        end
        r_lb[0][r_col] <= s.pix_data;
        for (int k = 1; k < KSIZE - 1; k++) r_lb[k][r_col] <= r_lb[k-1][r_col];
        for (int i = 0; i < KSIZE; i++)
          for (int j = 0; j < KSIZE - 1; j++) r_win[i][j] <= w_cur[i][j+1];
      end
      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_out_data <= w_res;
      end else if (s.out_ready) r_out_valid <= 1'b0;
    end
  end
endmodule
